// File: rtl/spi_dac_multi_if.sv
// Request/readback bus of the multi-channel SPI DAC writer.
// The master side requests writes and the slave side reports status and readback.
interface spi_dac_multi_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NCH    = 4
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*DATA_W-1:0] ch_data;
    logic [NCH-1:0]        ch_mask;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     rd_data;
    logic [CH_W-1:0]       rd_ch;
    logic                  rd_valid;

    modport master (
        output ch_data, ch_mask, start,
        input  busy, done, rd_data, rd_ch, rd_valid
    );

    modport slave (
        input  ch_data, ch_mask, start,
        output busy, done, rd_data, rd_ch, rd_valid
    );
endinterface

// File: rtl/spi_dac_multi.sv
// Writes every masked channel to its own SPI DAC in ascending order, then pulses the
// shared LDAc once so all DAC outputs update together. SDO readback is captured per frame.
module spi_dac_multi #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NCH       = 4,
    parameter int unsigned CLK_DIV   = 3,
    parameter int unsigned LDAC_W    = 2,
    parameter int unsigned CS_GAP    = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_l,
    spi_dac_multi_if.slave bus,
    input  logic           SDO,
    output logic           SDI,
    output logic           SCK,
    output logic [NCH-1:0] CSn,
    output logic           LDAc,
    output logic           CLRn
);
    localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BIT_W    = $clog2(DATA_W + 1);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned WAIT_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(CS_GAP - 1);
    localparam logic [WAIT_W-1:0] LDAC_LAST = WAIT_W'(LDAC_W - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        StIdle, StSelect, StCsSetup, StShift, StCsHold, StGap, StLdac, StDone
    } state_e;

    state_e                state_q;
    logic [NCH*DATA_W-1:0] data_q;
    logic [NCH-1:0]        mask_q;
    logic [CH_W-1:0]       ch_q;
    logic [DATA_W-1:0]     tx_q;
    logic [DATA_W-1:0]     rx_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [WAIT_W-1:0]     wait_cnt_q;

    logic [CH_W-1:0]   sel_ch;
    logic [DATA_W-1:0] sel_word;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_next;
    logic              first_bit;
    logic              next_bit;
    logic              div_end;

    assign CLRn = rst_l;

    always_comb begin
        sel_ch = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_ch = CH_W'(i);
        end
        sel_word  = data_q[sel_ch*DATA_W +: DATA_W];
        first_bit = MSB_FIRST ? sel_word[DATA_W-1] : sel_word[0];
        tx_shift  = MSB_FIRST ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};
        next_bit  = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
        rx_next   = MSB_FIRST ? {rx_q[DATA_W-2:0], SDO} : {SDO, rx_q[DATA_W-1:1]};
        div_end   = (div_cnt_q == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= StIdle;
            data_q       <= '0;
            mask_q       <= '0;
            ch_q         <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            SDI          <= 1'b0;
            SCK          <= 1'b0;
            CSn          <= '1;
            LDAc         <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_ch    <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        data_q   <= bus.ch_data;
                        mask_q   <= bus.ch_mask;
                        // An empty request only shows busy in its done cycle.
                        bus.busy <= |bus.ch_mask;
                        state_q  <= StSelect;
                    end
                end
                StSelect: begin
                    if (mask_q == '0) begin
                        bus.busy <= 1'b1;
                        bus.done <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        ch_q           <= sel_ch;
                        mask_q[sel_ch] <= 1'b0;
                        CSn            <= ~(NCH'(1) << sel_ch);
                        tx_q           <= sel_word;
                        SDI            <= first_bit;
                        div_cnt_q      <= '0;
                        state_q        <= StCsSetup;
                    end
                end
                StCsSetup: begin
                    if (div_end) begin
                        div_cnt_q <= '0;
                        SCK       <= 1'b1;
                        rx_q      <= rx_next;
                        bit_cnt_q <= BIT_W'(1);
                        state_q   <= StShift;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                StShift: begin
                    if (div_end) begin
                        div_cnt_q <= '0;
                        if (SCK) begin
                            SCK <= 1'b0;
                            if (bit_cnt_q != BIT_LAST) begin
                                tx_q <= tx_shift;
                                SDI  <= next_bit;
                            end
                        end else if (bit_cnt_q == BIT_LAST) begin
                            state_q <= StCsHold;
                        end else begin
                            SCK       <= 1'b1;
                            rx_q      <= rx_next;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                StCsHold: begin
                    if (div_end) begin
                        div_cnt_q    <= '0;
                        CSn          <= '1;
                        SDI          <= 1'b0;
                        bus.rd_data  <= rx_q;
                        bus.rd_ch    <= ch_q;
                        bus.rd_valid <= 1'b1;
                        wait_cnt_q   <= '0;
                        state_q      <= StGap;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                StGap: begin
                    if (wait_cnt_q == GAP_LAST) begin
                        wait_cnt_q <= '0;
                        if (mask_q != '0) begin
                            state_q <= StSelect;
                        end else begin
                            LDAc    <= 1'b0;
                            state_q <= StLdac;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StLdac: begin
                    if (wait_cnt_q == LDAC_LAST) begin
                        wait_cnt_q <= '0;
                        LDAc       <= 1'b1;
                        bus.done   <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StDone: begin
                    bus.busy <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_dac_multi.sv
// Scoreboard bench for spi_dac_multi: a 16-bit MSB-first instance and an 8-bit LSB-first one.
module tb_spi_dac_multi;
    localparam int unsigned DW = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned CD = 2;
    localparam int unsigned LW = 2;
    localparam int unsigned CG = 2;
    localparam int unsigned FRAME_LOW = (2 * DW + 2) * CD;

    typedef struct {
        int            ch;
        logic [DW-1:0] word;
    } frame_t;

    typedef struct {
        int frames;
        int ldac;
    } seq_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    spi_dac_multi_if #(.DATA_W(DW), .NCH(NC)) bus_a ();
    logic          sdo_a, sdi_a, sck_a, ldac_a, clrn_a;
    logic [NC-1:0] csn_a;

    spi_dac_multi #(
        .DATA_W(DW), .NCH(NC), .CLK_DIV(CD), .LDAC_W(LW), .CS_GAP(CG), .MSB_FIRST(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_l(rst_l), .bus(bus_a), .SDO(sdo_a), .SDI(sdi_a), .SCK(sck_a),
        .CSn(csn_a), .LDAc(ldac_a), .CLRn(clrn_a)
    );

    spi_dac_multi_if #(.DATA_W(8), .NCH(2)) bus_b ();
    logic       sdo_b, sdi_b, sck_b, ldac_b, clrn_b;
    logic [1:0] csn_b;

    spi_dac_multi #(
        .DATA_W(8), .NCH(2), .CLK_DIV(1), .LDAC_W(1), .CS_GAP(1), .MSB_FIRST(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_l(rst_l), .bus(bus_b), .SDO(sdo_b), .SDI(sdi_b), .SCK(sck_b),
        .CSn(csn_b), .LDAc(ldac_b), .CLRn(clrn_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    frame_t frame_q[$];
    frame_t rd_q[$];
    seq_t   seq_q[$];

    logic [DW-1:0] sdo_word [NC] = '{16'hC3A5, 16'h0F0F, 16'h5A5A, 16'h9001};

    // Monitor state for instance A
    logic [NC-1:0] m_pcsn;
    logic          m_psck, m_pldac, m_psdi;
    logic [DW-1:0] m_sdi_word;
    int            m_low, m_rise, m_ch, m_gap, m_ldac_w, m_seq_frames, m_seq_ldac;
    int            m_frames_total, m_done_cnt;
    bit            m_after_frame;
    int            viol_multi = 0, viol_sck = 0, viol_sdi = 0;

    initial begin
        frame_t f;
        seq_t   s;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                m_pcsn = '1; m_psck = 0; m_pldac = 1; m_psdi = 0; m_sdi_word = '0;
                m_low = 0; m_rise = 0; m_ch = -1; m_gap = 0; m_ldac_w = 0;
                m_seq_frames = 0; m_seq_ldac = 0; m_after_frame = 0;
                sdo_a = 1'b0;
            end else begin
                if ($countones(~csn_a) > 1) viol_multi++;
                if (&csn_a && sck_a) viol_sck++;
                if (m_psck && sck_a && sdi_a !== m_psdi) viol_sdi++;
                for (int c = 0; c < NC; c++) begin
                    if (m_pcsn[c] && !csn_a[c]) begin
                        if (m_after_frame) check_val("cs_gap_min", 32'(m_gap >= CG), 1);
                        m_ch = c; m_low = 0; m_rise = 0; m_sdi_word = '0;
                        sdo_a = sdo_word[c][DW-1];
                    end
                    if (!m_pcsn[c] && csn_a[c]) begin
                        if (frame_q.size() == 0) begin
                            check_val("frame_unexpected", frame_q.size(), 1);
                        end else begin
                            f = frame_q.pop_front();
                            check_val("frame_ch", c, f.ch);
                            check_val("frame_sdi_word", m_sdi_word, f.word);
                            check_val("frame_cs_low", m_low, FRAME_LOW);
                            check_val("frame_sck_rises", m_rise, DW);
                        end
                        m_after_frame = 1; m_gap = 0; m_ch = -1;
                        m_seq_frames++; m_frames_total++;
                    end
                end
                if (m_ch >= 0 && !csn_a[m_ch]) m_low++;
                if (!m_psck && sck_a) begin
                    m_sdi_word = {m_sdi_word[DW-2:0], sdi_a};
                    m_rise++;
                    if (m_rise < DW && m_ch >= 0) sdo_a = sdo_word[m_ch][DW-1-m_rise];
                end
                if (m_after_frame && &csn_a && ldac_a) m_gap++;
                if (m_pldac && !ldac_a) begin
                    check_val("ldac_after_gap", m_gap, CG);
                    check_val("ldac_after_frames", frame_q.size(), 0);
                    m_ldac_w = 0; m_seq_ldac++;
                end
                if (!ldac_a) m_ldac_w++;
                if (!m_pldac && ldac_a) begin
                    check_val("ldac_width", m_ldac_w, LW);
                    check_val("done_at_ldac_rise", bus_a.done, 1);
                end
                if (bus_a.rd_valid) begin
                    if (rd_q.size() == 0) begin
                        check_val("rd_unexpected", rd_q.size(), 1);
                    end else begin
                        f = rd_q.pop_front();
                        check_val("rd_ch", bus_a.rd_ch, f.ch);
                        check_val("rd_data", bus_a.rd_data, f.word);
                    end
                end
                if (bus_a.done) begin
                    m_done_cnt++;
                    if (seq_q.size() == 0) begin
                        check_val("done_unexpected", seq_q.size(), 1);
                    end else begin
                        s = seq_q.pop_front();
                        check_val("seq_frames", m_seq_frames, s.frames);
                        check_val("seq_ldac_pulses", m_seq_ldac, s.ldac);
                    end
                    m_after_frame = 0; m_seq_frames = 0; m_seq_ldac = 0;
                end
                m_pcsn = csn_a; m_psck = sck_a; m_pldac = ldac_a; m_psdi = sdi_a;
            end
        end
    end

    task automatic do_start(input logic [NC-1:0] mask, input logic [NC*DW-1:0] data);
        seq_t   s;
        frame_t f;
        @(negedge clk);
        bus_a.ch_mask = mask;
        bus_a.ch_data = data;
        bus_a.start   = 1'b1;
        s.frames = $countones(mask);
        s.ldac   = (mask != 0) ? 1 : 0;
        seq_q.push_back(s);
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                f.ch = c; f.word = data[c*DW +: DW]; frame_q.push_back(f);
                f.word = sdo_word[c]; rd_q.push_back(f);
            end
        end
        @(negedge clk);
        bus_a.start   = 1'b0;
        bus_a.ch_mask = ~mask;
        bus_a.ch_data = {$urandom, $urandom};
        check_val("busy_after_start", bus_a.busy, 32'(mask != 0));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus_a.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("done_within_budget", 32'(n < budget), 1);
        @(negedge clk);
    endtask

    initial begin
        int            n, frames_before, done_before, b_low, b_rise, b_rd, b_csn1;
        logic [7:0]    b_word, b_exp;
        logic          b_psck;
        logic [7:0]    b_q[$];

        bus_a.start = 0; bus_a.ch_mask = '0; bus_a.ch_data = '0;
        bus_b.start = 0; bus_b.ch_mask = '0; bus_b.ch_data = '0;
        sdo_b = 1'b1;
        m_frames_total = 0; m_done_cnt = 0;

        #12;
        check_val("rst_csn", csn_a, 4'hF);
        check_val("rst_sck", sck_a, 0);
        check_val("rst_sdi", sdi_a, 0);
        check_val("rst_ldac", ldac_a, 1);
        check_val("rst_busy", bus_a.busy, 0);
        check_val("rst_done", bus_a.done, 0);
        check_val("rst_rd_valid", bus_a.rd_valid, 0);
        check_val("rst_rd_data", bus_a.rd_data, 0);
        check_val("rst_rd_ch", bus_a.rd_ch, 0);
        check_val("rst_clrn", clrn_a, 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check_val("clrn_released", clrn_a, 1);

        do_start(4'b0001, {16'h1111, 16'h2222, 16'h3333, 16'hA5C3});
        wait_done(2000);
        do_start(4'b1010, {16'hFFFF, 16'h4444, 16'h1234, 16'h5555});
        wait_done(2000);
        do_start(4'b0100, {16'h0000, 16'h8001, 16'h7777, 16'h6666});
        wait_done(2000);

        // Empty mask: done two cycles after start, no bus activity
        frames_before = m_frames_total;
        do_start(4'b0000, {16'h1, 16'h2, 16'h3, 16'h4});
        check_val("empty_done_early", bus_a.done, 0);
        @(negedge clk);
        check_val("empty_done", bus_a.done, 1);
        check_val("empty_busy", bus_a.busy, 1);
        @(negedge clk);
        check_val("empty_done_clear", bus_a.done, 0);
        check_val("empty_busy_clear", bus_a.busy, 0);
        check_val("empty_no_frames", m_frames_total, frames_before);

        // A second start while busy must be dropped
        frames_before = m_frames_total;
        do_start(4'b1001, {16'hBEEF, 16'h0001, 16'h0002, 16'hCAFE});
        repeat (40) @(negedge clk);
        bus_a.ch_mask = 4'b1111; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done(2000);
        repeat (20) @(negedge clk);
        check_val("ignored_start_frames", m_frames_total - frames_before, 2);
        check_val("ignored_start_idle", bus_a.busy, 0);

        // Reset during the 8th SCK period
        do_start(4'b0010, {16'h0, 16'hF00D, 16'h0, 16'h0});
        n = 0;
        while (m_rise < 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_8th_sck", 32'(n < 2000), 1);
        #2;
        rst_l = 1'b0;
        #1;
        check_val("midrst_csn", csn_a, 4'hF);
        check_val("midrst_sck", sck_a, 0);
        check_val("midrst_ldac", ldac_a, 1);
        check_val("midrst_busy", bus_a.busy, 0);
        frame_q.delete(); rd_q.delete(); seq_q.delete();
        done_before = m_done_cnt;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (5) @(negedge clk);
        check_val("midrst_no_done", m_done_cnt, done_before);
        do_start(4'b0100, {16'h0, 16'h3C3C, 16'h0, 16'h0});
        wait_done(2000);

        check_val("viol_multi_cs", viol_multi, 0);
        check_val("viol_sck_idle", viol_sck, 0);
        check_val("viol_sdi_stable", viol_sdi, 0);
        check_val("frame_q_drained", frame_q.size(), 0);
        check_val("rd_q_drained", rd_q.size(), 0);
        check_val("seq_q_drained", seq_q.size(), 0);

        // LSB-first, 8-bit, CLK_DIV=1 instance
        @(negedge clk);
        bus_b.ch_mask = 2'b01; bus_b.ch_data = 16'h0001; bus_b.start = 1'b1;
        b_q.push_back(8'h01);
        @(negedge clk);
        bus_b.start = 1'b0;
        b_low = 0; b_rise = 0; b_rd = 0; b_csn1 = 0; b_word = '0; b_psck = 1'b0;
        n = 0;
        while (!bus_b.done && n < 200) begin
            if (!csn_b[0]) b_low++;
            if (!csn_b[1]) b_csn1++;
            if (sck_b && !b_psck) begin
                if (b_rise < 8) b_word[b_rise] = sdi_b;
                b_rise++;
            end
            b_psck = sck_b;
            if (bus_b.rd_valid) begin
                b_rd++;
                check_val("b_rd_data", bus_b.rd_data, 8'hFF);
                check_val("b_rd_ch", bus_b.rd_ch, 0);
            end
            @(negedge clk);
            n++;
        end
        check_val("b_done_within_budget", 32'(n < 200), 1);
        b_exp = b_q.pop_front();
        check_val("b_first_sdi", b_word[0], 1);
        check_val("b_sdi_word", b_word, b_exp);
        check_val("b_cs_low", b_low, 18);
        check_val("b_sck_rises", b_rise, 8);
        check_val("b_rd_pulses", b_rd, 1);
        check_val("b_csn1_idle", b_csn1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_dac_multi.md
Name: spi_dac_multi

Overview:
- Multi-channel successor to the single-DAC SPI write controller.
- Drives up to NCH SPI DACs that share SCK, SDI and LDAc, with one CSn per channel.
- One start request writes every channel selected in a mask, in ascending index order, then pulses the shared LDAc once so all DAC outputs update together.
- Captures SDO readback per channel, and word width, SCK rate, LDAC width and inter-frame gap are all parametrised.

Parameters:
- DATA_W, 16, bits per SPI frame (>=2).
- NCH, 4, number of DAC channels (>=1).
- CLK_DIV, 3, SCK half-period in clk cycles (>=1).
- LDAC_W, 2, LDAc low pulse width in clk cycles (>=1).
- CS_GAP, 2, minimum clk cycles with all CSn high between frames (>=1).
- MSB_FIRST, 1, 1 = shift bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- ch_data  in  NCH*DATA_W  channel i word at [i*DATA_W +: DATA_W].
- ch_mask  in  NCH  channels to write on this request.
- start  in  1  request pulse, sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the sequence completes.
- rd_data  out  DATA_W  SDO word captured during the last completed frame.
- rd_ch  out  $clog2(NCH) (min 1)  channel index belonging to rd_data.
- rd_valid  out  1  one-cycle pulse when rd_data/rd_ch update.
- SDO  in  1  shared serial readback from the DACs.
- SDI  out  1  shared serial data to the DACs.
- SCK  out  1  shared serial clock, SPI mode 0, idles low.
- CSn  out  NCH  per-channel chip select, active low.
- LDAc  out  1  shared load strobe, active low.
- CLRn  out  1  equals rst_l (combinational).

Behaviour:
- Reset (asynchronous, takes effect immediately): SCK=0, SDI=0, CSn=all 1, LDAc=1, busy=0, done=0, rd_valid=0, rd_data=0, rd_ch=0, state=IDLE.
- Reset mid-frame aborts at once, with no LDAc pulse and no done.
- All outputs except CLRn are registered.
- Request acceptance (IDLE, start=1):
  - ch_data and ch_mask are latched the same cycle.
  - Later changes to the inputs do not affect the running sequence.
  - start while busy is ignored, not queued.
- Empty mask: if the latched mask is 0, done pulses 2 cycles after start; busy is high only in the done cycle; there is no CSn, SCK or LDAc activity.
- States: IDLE -> SELECT -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> (SELECT | LDAC) -> DONE -> IDLE.
- SELECT (1 cycle): picks the lowest-index remaining masked channel and clears its mask bit.
- CS_SETUP (CLK_DIV cycles):
  - CSn[i]=0 and all other CSn=1.
  - SDI = first bit (MSB if MSB_FIRST, else LSB); SCK=0.
- SHIFT (2*DATA_W*CLK_DIV cycles):
  - SCK toggles every CLK_DIV cycles, starting with a rising edge.
  - Each rising edge samples SDO into the receive shift register, in the same bit order as transmit.
  - Each falling edge except the last presents the next SDI bit.
  - Exactly DATA_W rising edges per frame; SCK ends low.
- CS_HOLD (CLK_DIV cycles): CSn[i] stays low, SCK=0.
- CSn[i] low time is exactly (2*DATA_W+2)*CLK_DIV cycles.
- Frame end, on exit of CS_HOLD:
  - CSn[i] goes high.
  - rd_data takes the received word, rd_ch=i, rd_valid pulses 1 cycle.
- GAP (CS_GAP cycles): all CSn high, SDI=0.
- After GAP: go to SELECT if mask bits remain, else LDAC.
- LDAC: LDAc=0 for LDAC_W cycles, then 1.
- DONE (1 cycle): done=1, busy=1. The next cycle is IDLE with busy=0, and start is accepted in that cycle.
- Invariants: at most one CSn low at any time; SCK=0 whenever all CSn are high; SDI stable while SCK is high.
- Counters: the bit counter is sized $clog2(DATA_W+1) and the divider counter $clog2(CLK_DIV+1), with no wrap inside a frame. The channel index never exceeds NCH-1.

Test Plan:
- DATA_W=16, CLK_DIV=2, NCH=4, mask=4'b0001, ch0=16'hA5C3:
  - CSn[0] low 68 cycles, 16 SCK rising edges.
  - SDI bits on rising edges = 1010_0101_1100_0011; CSn[3:1] stay high.
  - LDAc low 2 cycles after GAP, then done.
- mask=4'b1010, ch1=16'h1234, ch3=16'hFFFF:
  - Frames on CSn[1] then CSn[3], with at least CS_GAP=2 cycles all-high between them; CSn[0] and CSn[2] never low.
  - Exactly one LDAc pulse, after the ch3 frame.
- SDO driven with 16'h5A5A during the ch2 frame: rd_valid pulses once with rd_ch=2, rd_data=16'h5A5A.
- Request handling:
  - mask=0 with start -> done 2 cycles later, CSn and LDAc never change.
  - start pulsed again mid-sequence -> ignored, and the frame count equals popcount of the original mask.
- Reset behaviour:
  - rst_l low during the 8th SCK period -> CSn=4'hF, SCK=0, LDAc=1, busy=0 at once, and no done.
  - After release, a new start with mask=4'b0100 completes normally.
- MSB_FIRST=0, DATA_W=8, CLK_DIV=1, data 8'h01 -> first SDI bit is 1, remaining 7 bits 0, CSn low 18 cycles.
